// File: rtl/sensor_image_tx_pkg.sv
// Shared types and constants for the sensor-style video transmitter.
package sensor_image_tx_pkg;

  // Vertical frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC_LOW,
    ST_V_PRE,
    ST_ACTIVE,
    ST_V_POST
  } tx_state_e;

  // Sub-phases of one active line.
  typedef enum logic {
    PH_HREF,
    PH_HBLANK
  } line_phase_e;

  // Size fields that cannot be zero are raised to this value.
  localparam int unsigned MIN_SIZE = 1;

endpackage

// File: rtl/sensor_image_tx_line_ctrl.sv
// Horizontal sequencing of one active line: HREF until h_active transfers, then HBLANK.
module sensor_image_tx_line_ctrl
  import sensor_image_tx_pkg::*;
#(
  parameter int unsigned H_COUNTER_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run_i,
  input  logic [H_COUNTER_WIDTH-1:0] h_active_i,
  input  logic [H_COUNTER_WIDTH-1:0] h_blank_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_c,
  output logic                       xfer_c,
  output logic                       eol_c
);

  localparam int unsigned HW = H_COUNTER_WIDTH;

  line_phase_e   phase_q, phase_d;
  logic [HW-1:0] cnt_q, cnt_d;

  // Ready depends only on phase, never on s_valid.
  assign s_ready_c = run_i && (phase_q == PH_HREF);
  assign xfer_c    = s_ready_c && s_valid_i;
  assign eol_c     = run_i && (phase_q == PH_HBLANK) && (cnt_q == h_blank_i - HW'(1));

  // Counter counts transfers in HREF and cycles in HBLANK.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (xfer_c) begin
      if (cnt_q == h_active_i - HW'(1)) begin
        phase_d = PH_HBLANK;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end else if (eol_c) begin
      phase_d = PH_HREF;
      cnt_d   = '0;
    end else if (run_i && (phase_q == PH_HBLANK)) begin
      cnt_d = cnt_q + HW'(1);
    end
  end

  // Phase and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_HREF;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_image_tx.sv
// Sensor-style vsync/href/de transmitter fed from a valid/ready pixel source.
module sensor_image_tx
  import sensor_image_tx_pkg::*;
#(
  parameter int unsigned PIXEL_DATA_WIDTH = 8,
  parameter int unsigned H_COUNTER_WIDTH  = 12,
  parameter int unsigned V_COUNTER_WIDTH  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic [H_COUNTER_WIDTH-1:0]  h_active_i,
  input  logic [H_COUNTER_WIDTH-1:0]  h_blank_i,
  input  logic [V_COUNTER_WIDTH-1:0]  v_sync_i,
  input  logic [V_COUNTER_WIDTH-1:0]  v_pre_i,
  input  logic [V_COUNTER_WIDTH-1:0]  v_active_i,
  input  logic [V_COUNTER_WIDTH-1:0]  v_post_i,
  input  logic                        s_valid,
  input  logic [PIXEL_DATA_WIDTH-1:0] s_data,
  output logic                        s_ready,
  output logic                        image_out_vsync,
  output logic                        image_out_href,
  output logic                        image_out_de,
  output logic [PIXEL_DATA_WIDTH-1:0] image_out_data,
  output logic                        frame_done_o,
  output logic                        line_stall_o
);

  localparam int unsigned HW = H_COUNTER_WIDTH;
  localparam int unsigned VW = V_COUNTER_WIDTH;
  localparam int unsigned LW = H_COUNTER_WIDTH + 1;

  tx_state_e     state_q, state_d, start_state_c;
  logic [LW-1:0] cyc_q, cyc_d, line_len_c;
  logic [VW-1:0] line_q, line_d, span_lines_c;
  logic          cfg_load_c, frame_end_c, span_done_c;
  logic          ready_c, xfer_c, eol_c;

  logic [HW-1:0] cfg_h_active_q, cfg_h_blank_q;
  logic [VW-1:0] cfg_v_sync_q, cfg_v_pre_q, cfg_v_active_q, cfg_v_post_q;

  logic                        vsync_q, href_q, de_q, frame_done_q, stall_q;
  logic [PIXEL_DATA_WIDTH-1:0] data_q;

  // Line period in blanking states, one bit wider so it cannot wrap.
  assign line_len_c = LW'(cfg_h_active_q) + LW'(cfg_h_blank_q);

  sensor_image_tx_line_ctrl #(
    .H_COUNTER_WIDTH (H_COUNTER_WIDTH)
  ) u_line_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (state_q == ST_ACTIVE),
    .h_active_i (cfg_h_active_q),
    .h_blank_i  (cfg_h_blank_q),
    .s_valid_i  (s_valid),
    .s_ready_c  (ready_c),
    .xfer_c     (xfer_c),
    .eol_c      (eol_c)
  );

  assign s_ready = ready_c;

  // First state of a new frame, decided from the live inputs being latched.
  always_comb begin
    start_state_c = ST_ACTIVE;
    if (v_sync_i != '0) begin
      start_state_c = ST_VSYNC_LOW;
    end else if (v_pre_i != '0) begin
      start_state_c = ST_V_PRE;
    end
  end

  // Line count of the current blanking span.
  always_comb begin
    span_lines_c = '0;
    case (state_q)
      ST_VSYNC_LOW: span_lines_c = cfg_v_sync_q;
      ST_V_PRE:     span_lines_c = cfg_v_pre_q;
      ST_V_POST:    span_lines_c = cfg_v_post_q;
      default:      span_lines_c = '0;
    endcase
  end

  // Vertical FSM next state; zero-length spans are skipped without a gap.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    line_d      = line_q;
    cfg_load_c  = 1'b0;
    frame_end_c = 1'b0;
    span_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d    = start_state_c;
          cfg_load_c = 1'b1;
        end
      end
      ST_VSYNC_LOW, ST_V_PRE, ST_V_POST: begin
        if (cyc_q == line_len_c - LW'(1)) begin
          cyc_d = '0;
          if (line_q == span_lines_c - VW'(1)) begin
            line_d      = '0;
            span_done_c = 1'b1;
          end else begin
            line_d = line_q + VW'(1);
          end
        end else begin
          cyc_d = cyc_q + LW'(1);
        end
      end
      ST_ACTIVE: begin
        if (eol_c) begin
          if (line_q == cfg_v_active_q - VW'(1)) begin
            line_d      = '0;
            span_done_c = 1'b1;
          end else begin
            line_d = line_q + VW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (span_done_c) begin
      case (state_q)
        ST_VSYNC_LOW: state_d = (cfg_v_pre_q != '0) ? ST_V_PRE : ST_ACTIVE;
        ST_V_PRE:     state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (cfg_v_post_q != '0) begin
            state_d = ST_V_POST;
          end else begin
            frame_end_c = 1'b1;
          end
        end
        ST_V_POST:    frame_end_c = 1'b1;
        default:      state_d = ST_IDLE;
      endcase
    end
    if (frame_end_c) begin
      if (enable_i) begin
        state_d    = start_state_c;
        cfg_load_c = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State, counters and per-frame configuration snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cyc_q          <= '0;
      line_q         <= '0;
      cfg_h_active_q <= HW'(MIN_SIZE);
      cfg_h_blank_q  <= HW'(MIN_SIZE);
      cfg_v_sync_q   <= '0;
      cfg_v_pre_q    <= '0;
      cfg_v_active_q <= VW'(MIN_SIZE);
      cfg_v_post_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      line_q  <= line_d;
      if (cfg_load_c) begin
        cfg_h_active_q <= (h_active_i == '0) ? HW'(MIN_SIZE) : h_active_i;
        cfg_h_blank_q  <= (h_blank_i == '0) ? HW'(MIN_SIZE) : h_blank_i;
        cfg_v_sync_q   <= v_sync_i;
        cfg_v_pre_q    <= v_pre_i;
        cfg_v_active_q <= (v_active_i == '0) ? VW'(MIN_SIZE) : v_active_i;
        cfg_v_post_q   <= v_post_i;
      end
    end
  end

  // Output stage: one cycle behind state and handshake; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      de_q         <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      vsync_q      <= (state_q == ST_V_PRE) || (state_q == ST_ACTIVE) || (state_q == ST_V_POST);
      href_q       <= ready_c;
      de_q         <= xfer_c;
      stall_q      <= ready_c && !s_valid;
      frame_done_q <= frame_end_c;
      if (xfer_c) begin
        data_q <= s_data;
      end
    end
  end

  assign image_out_vsync = vsync_q;
  assign image_out_href  = href_q;
  assign image_out_de    = de_q;
  assign image_out_data  = data_q;
  assign frame_done_o    = frame_done_q;
  assign line_stall_o    = stall_q;

endmodule

// File: tb/tb_sensor_image_tx.sv
// Self-checking bench for sensor_image_tx with a pixel scoreboard and line/frame monitor.
`timescale 1ns/1ps
module tb_sensor_image_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned HW = 12;
  localparam int unsigned VW = 12;
  localparam int W_VSYNC = 0;
  localparam int W_HREF  = 1;
  localparam int W_FD    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [HW-1:0] h_active_i = '0, h_blank_i = '0;
  logic [VW-1:0] v_sync_i = '0, v_pre_i = '0, v_active_i = '0, v_post_i = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          image_out_vsync, image_out_href, image_out_de;
  logic [DW-1:0] image_out_data;
  logic          frame_done_o, line_stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard and monitor state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] crop_exp[$], crop_got[$];
  int   hlens[$], hdes[$], hstalls[$], vlows[$];
  int   cur_len = 0, cur_de = 0, cur_stall = 0, vlow_cnt = 0, vline = 0, fd_cnt = 0;
  logic href_prev = 1'b0, vsync_prev = 1'b0;
  bit   crop_en = 1'b0;
  int   src_mode = 0;
  logic [DW-1:0] src_next = 8'h01;
  logic alt = 1'b0;

  sensor_image_tx #(
    .PIXEL_DATA_WIDTH (DW),
    .H_COUNTER_WIDTH  (HW),
    .V_COUNTER_WIDTH  (VW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .h_active_i      (h_active_i),
    .h_blank_i       (h_blank_i),
    .v_sync_i        (v_sync_i),
    .v_pre_i         (v_pre_i),
    .v_active_i      (v_active_i),
    .v_post_i        (v_post_i),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .image_out_vsync (image_out_vsync),
    .image_out_href  (image_out_href),
    .image_out_de    (image_out_de),
    .image_out_data  (image_out_data),
    .frame_done_o    (frame_done_o),
    .line_stall_o    (line_stall_o)
  );

  always #5 clk = ~clk;

  // Source: drive on negedge, record accepted pixels just before the posedge.
  initial begin
    forever begin
      @(negedge clk);
      alt     = ~alt;
      s_valid = (src_mode == 0) ? 1'b1 : alt;
      s_data  = src_next;
      #4;
      if (rst_n && s_valid && s_ready) begin
        exp_q.push_back(s_data);
        src_next = src_next + 8'd1;
      end
    end
  end

  // Output monitor: pixel scoreboard, line/frame statistics, crop model.
  always @(negedge clk) begin
    if (image_out_de) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: de=1 data=%0h, required no pixel", image_out_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (image_out_data !== exp_d) begin
          n_bad++;
          $display("FAIL pixel_data: got %0h required %0h", image_out_data, exp_d);
        end
      end
    end
    if (image_out_href || line_stall_o) begin
      n_cmp++;
      if (line_stall_o !== (image_out_href && !image_out_de)) begin
        n_bad++;
        $display("FAIL stall_flag: stall=%0b required %0b", line_stall_o, image_out_href && !image_out_de);
      end
    end
    if (image_out_href) begin
      if (crop_en && image_out_de && vline < 2 && cur_de >= 1 && cur_de < 3)
        crop_got.push_back(image_out_data);
      cur_len++;
      if (image_out_de) cur_de++;
      if (line_stall_o) cur_stall++;
    end else if (href_prev) begin
      hlens.push_back(cur_len);
      hdes.push_back(cur_de);
      hstalls.push_back(cur_stall);
      vline++;
      cur_len = 0; cur_de = 0; cur_stall = 0;
    end
    if (!image_out_vsync) begin
      vlow_cnt++;
      vline = 0;
    end else if (!vsync_prev) begin
      vlows.push_back(vlow_cnt);
      vlow_cnt = 0;
    end
    if (frame_done_o) fd_cnt++;
    href_prev  = image_out_href;
    vsync_prev = image_out_vsync;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int what, input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick(1);
      case (what)
        W_VSYNC: ok = (image_out_vsync === 1'b1);
        W_HREF:  ok = (image_out_href === 1'b1);
        default: ok = (fd_cnt >= target);
      endcase
    end
  endtask

  task automatic set_cfg(input int ha, input int hb, input int vs, input int vp, input int va, input int vo);
    h_active_i = HW'(ha); h_blank_i = HW'(hb);
    v_sync_i = VW'(vs); v_pre_i = VW'(vp); v_active_i = VW'(va); v_post_i = VW'(vo);
  endtask

  task automatic clear_stats();
    hlens.delete(); hdes.delete(); hstalls.delete(); vlows.delete();
    cur_len = 0; cur_de = 0; cur_stall = 0; vlow_cnt = 0; fd_cnt = 0;
  endtask

  task automatic test_reset();
    set_cfg(4, 2, 1, 1, 3, 1);
    tick(3);
    n_cmp++;
    if ({image_out_vsync, image_out_href, image_out_de, image_out_data, frame_done_o, line_stall_o, s_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%0b h=%0b de=%0b d=%0h fd=%0b st=%0b rdy=%0b required all 0",
               image_out_vsync, image_out_href, image_out_de, image_out_data, frame_done_o, line_stall_o, s_ready);
    end
    rst_n = 1'b1;
    tick(5);
    n_cmp++;
    if (image_out_vsync !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got vsync=%0b ready=%0b required 0 0", image_out_vsync, s_ready);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    src_mode = 0;
    set_cfg(4, 2, 1, 1, 3, 1);
    clear_stats();
    enable_i = 1'b1;
    wait_for(W_FD, 1, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_frame1_done: got none, required frame_done within 400 cycles"); end
    enable_i = 1'b0;
    wait_for(W_FD, 2, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_frame2_done: got none, required frame_done within 400 cycles"); end
    tick(4);
    n_cmp++;
    if (hlens.size() != 6) begin n_bad++; $display("FAIL basic_line_count: got %0d required 6", hlens.size()); end
    foreach (hlens[i]) begin
      n_cmp++;
      if (hlens[i] != 4 || hdes[i] != 4) begin
        n_bad++;
        $display("FAIL basic_href_len: line %0d got len=%0d de=%0d required 4 4", i, hlens[i], hdes[i]);
      end
    end
    n_cmp++;
    if (vlows.size() < 2) begin
      n_bad++;
      $display("FAIL basic_vsync_edges: got %0d rises required 2", vlows.size());
    end else if (vlows[1] != 6) begin
      n_bad++;
      $display("FAIL basic_vsync_low: got %0d cycles required 6", vlows[1]);
    end
    n_cmp++;
    if (fd_cnt != 2) begin n_bad++; $display("FAIL basic_frame_done_count: got %0d required 2", fd_cnt); end
  endtask

  task automatic test_source_stalls();
    bit ok;
    src_mode = 1;
    set_cfg(4, 2, 1, 1, 3, 1);
    clear_stats();
    enable_i = 1'b1;
    wait_for(W_VSYNC, 0, 200, ok);
    enable_i = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_start: got vsync low, required high within 200 cycles"); end
    wait_for(W_FD, 1, 600, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_done: got none, required frame_done within 600 cycles"); end
    tick(4);
    n_cmp++;
    if (hlens.size() != 3) begin n_bad++; $display("FAIL stall_line_count: got %0d required 3", hlens.size()); end
    foreach (hlens[i]) begin
      n_cmp++;
      if (hlens[i] < 7 || hlens[i] > 8 || hdes[i] != 4 || hstalls[i] != hlens[i] - 4) begin
        n_bad++;
        $display("FAIL stall_line: line %0d got len=%0d de=%0d stalls=%0d required len 7..8 de 4 stalls len-4",
                 i, hlens[i], hdes[i], hstalls[i]);
      end
    end
    src_mode = 0;
  endtask

  task automatic test_zero_clamp();
    set_cfg(0, 0, 0, 0, 0, 0);
    clear_stats();
    enable_i = 1'b1;
    tick(20);
    enable_i = 1'b0;
    tick(6);
    n_cmp++;
    if (hlens.size() < 8) begin n_bad++; $display("FAIL zero_line_count: got %0d required at least 8", hlens.size()); end
    foreach (hlens[i]) begin
      n_cmp++;
      if (hlens[i] != 1 || hdes[i] != 1) begin
        n_bad++;
        $display("FAIL zero_line_len: line %0d got len=%0d de=%0d required 1 1", i, hlens[i], hdes[i]);
      end
    end
    n_cmp++;
    if (fd_cnt != hlens.size()) begin
      n_bad++;
      $display("FAIL zero_lines_per_frame: got %0d frames for %0d lines required equal", fd_cnt, hlens.size());
    end
    n_cmp++;
    if (image_out_vsync !== 1'b0 || image_out_href !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_idle: got vsync=%0b href=%0b required 0 0", image_out_vsync, image_out_href);
    end
  endtask

  task automatic test_midframe_change();
    bit ok;
    set_cfg(4, 2, 1, 1, 3, 1);
    clear_stats();
    enable_i = 1'b1;
    wait_for(W_HREF, 0, 200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_href: got href low, required high within 200 cycles"); end
    h_active_i = HW'(8);
    enable_i   = 1'b0;
    wait_for(W_FD, 1, 400, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_done: got none, required frame_done within 400 cycles"); end
    tick(3);
    n_cmp++;
    if (hlens.size() != 3) begin n_bad++; $display("FAIL mid_line_count: got %0d required 3", hlens.size()); end
    foreach (hlens[i]) begin
      n_cmp++;
      if (hlens[i] != 4) begin n_bad++; $display("FAIL mid_line_len: line %0d got %0d required 4", i, hlens[i]); end
    end
    tick(20);
    n_cmp++;
    if ({image_out_vsync, image_out_href, image_out_de, frame_done_o, line_stall_o, s_ready} !== '0 || fd_cnt != 1) begin
      n_bad++;
      $display("FAIL mid_idle: got v=%0b h=%0b de=%0b fd=%0b st=%0b rdy=%0b frames=%0d required all 0, 1 frame",
               image_out_vsync, image_out_href, image_out_de, frame_done_o, line_stall_o, s_ready, fd_cnt);
    end
    h_active_i = HW'(4);
  endtask

  task automatic test_reset_midline();
    bit ok;
    set_cfg(4, 2, 1, 1, 3, 1);
    enable_i = 1'b1;
    wait_for(W_HREF, 0, 200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_href: got href low, required high within 200 cycles"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({image_out_vsync, image_out_href, image_out_de, image_out_data, frame_done_o, line_stall_o, s_ready} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got v=%0b h=%0b de=%0b d=%0h fd=%0b st=%0b rdy=%0b required all 0",
               image_out_vsync, image_out_href, image_out_de, image_out_data, frame_done_o, line_stall_o, s_ready);
    end
    enable_i = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b1;
    tick(10);
    n_cmp++;
    if (image_out_vsync !== 1'b0 || s_ready !== 1'b0 || image_out_href !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_stay_idle: got vsync=%0b ready=%0b href=%0b required 0 0 0", image_out_vsync, s_ready, image_out_href);
    end
    exp_q.delete();
    clear_stats();
    enable_i = 1'b1;
    wait_for(W_VSYNC, 0, 200, ok);
    enable_i = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_restart: got vsync low, required high within 200 cycles"); end
    wait_for(W_FD, 1, 400, ok);
    tick(3);
    n_cmp++;
    if (!ok || hlens.size() != 3) begin
      n_bad++;
      $display("FAIL rst_frame_after: got done=%0b lines=%0d required 1 3", ok, hlens.size());
    end
  endtask

  task automatic test_loopback();
    bit ok;
    set_cfg(4, 2, 1, 1, 3, 1);
    src_next = 8'h10;
    crop_exp.delete();
    crop_got.delete();
    crop_exp.push_back(8'h11); crop_exp.push_back(8'h12);
    crop_exp.push_back(8'h15); crop_exp.push_back(8'h16);
    crop_en = 1'b1;
    clear_stats();
    enable_i = 1'b1;
    wait_for(W_VSYNC, 0, 200, ok);
    enable_i = 1'b0;
    wait_for(W_FD, 1, 400, ok);
    tick(3);
    crop_en = 1'b0;
    n_cmp++;
    if (!ok || crop_got.size() != 4) begin
      n_bad++;
      $display("FAIL crop_count: got done=%0b pixels=%0d required 1 4", ok, crop_got.size());
    end
    for (int i = 0; i < crop_got.size() && i < 4; i++) begin
      n_cmp++;
      if (crop_got[i] !== crop_exp[i]) begin
        n_bad++;
        $display("FAIL crop_pixel: idx %0d got %0h required %0h", i, crop_got[i], crop_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_source_stalls();
    test_zero_clamp();
    test_midframe_change();
    test_reset_midline();
    test_loopback();
    tick(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pixels never emitted, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500 us, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sensor_image_tx.md
# sensor_image_tx

Sensor-style video stream transmitter: pulls pixels from a valid/ready source and emits a `vsync`/`href`/`de`/`data` stream with runtime-configurable active size and blanking. It uses the same polarity conventions as the crop path: `vsync` high = frame valid, `href` high = line, `de` high = valid pixel. It sits at the head of the image pipeline, driving test patterns or frame-buffer readback into the crop/scale chain in place of a physical sensor.

## Interface
- `PIXEL_DATA_WIDTH`, 8, pixel bus width
- `H_COUNTER_WIDTH`, 12, width of horizontal config and counters
- `V_COUNTER_WIDTH`, 12, width of vertical config and counters

Ports:
- `clk` in 1: pixel clock; the block has one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable_i` in 1: high = generate frames continuously; low = finish the current frame, then idle.
- `h_active_i` in H: pixels per line; 0 is treated as 1.
- `h_blank_i` in H: `href`-low cycles after each line; 0 is treated as 1.
- `v_sync_i` in V: lines with `vsync` low at frame start; 0 is allowed.
- `v_pre_i` in V: lines with `vsync` high and `href` low before the active lines; 0 is allowed.
- `v_active_i` in V: active lines; 0 is treated as 1.
- `v_post_i` in V: lines with `vsync` high and `href` low after the active lines; 0 is allowed.
- `s_valid` in 1: source pixel valid.
- `s_data` in PIXEL_DATA_WIDTH: source pixel.
- `s_ready` out 1: source pixel accepted when `s_valid && s_ready`.
- `image_out_vsync` out 1: frame valid.
- `image_out_href` out 1: line valid.
- `image_out_de` out 1: pixel valid.
- `image_out_data` out PIXEL_DATA_WIDTH: pixel data.
- `frame_done_o` out 1: one-cycle pulse at the end of `V_POST`.
- `line_stall_o` out 1: registered; high for each cycle `href` is high with no transfer.

## Operation
- All config inputs are latched into internal registers on every transition into `VSYNC_LOW`. Config changes mid-frame have no effect until the next frame.
- Line period in non-active states: L = h_active + h_blank cycles, computed at H+1 bits with no overflow.
- States and transitions:
  - `IDLE`: go to `VSYNC_LOW` when `enable_i` = 1.
  - `VSYNC_LOW`: lasts v_sync·L cycles, then `V_PRE`.
  - `V_PRE`: lasts v_pre·L cycles, then `ACTIVE`.
  - `ACTIVE`: lasts v_active lines, then `V_POST`.
  - `V_POST`: lasts v_post·L cycles. At its end, pulse `frame_done_o`, then go to `VSYNC_LOW` if `enable_i` = 1, else `IDLE`.
  - States with a zero count are skipped with no idle cycle.
- `ACTIVE` line sub-phases:
  - `HREF`: `s_ready` = 1 until h_active transfers are complete.
  - `HBLANK`: lasts h_blank cycles with `s_ready` = 0.
- Underflow: `href` stays high until all h_active pixels have transferred, so a line is stretched, never truncated. Each such cycle has `de` = 0 and `line_stall_o` = 1.
- `s_ready` is combinational from state and pixel counter only. It must not depend on `s_valid`.
- `image_out_vsync` is low in `IDLE` and `VSYNC_LOW`, high otherwise.
- `enable_i` falling mid-frame does not truncate the frame.

## Timing
- Reset values: every output is 0, and the state is `IDLE`.
- All `image_out_*` outputs are registered, with 1-cycle latency. Handshake in cycle n means `de` = 1 and `data` = `s_data` in cycle n+1.
- `image_out_data` holds its last value when `de` = 0.
- `image_out_href` asserts in the cycle after entry to `HREF` and deasserts in the cycle after the last transfer. The minimum gap between lines is 1 cycle, so an `href` negedge always occurs.
- The `image_out_vsync` edge aligns with the state change, delayed by 1 cycle.
- `enable_i` rising in `IDLE` at cycle n: config latched at n+1; `vsync` remains low.
- Asynchronous reset mid-frame returns to `IDLE` immediately. A partial frame is abandoned and the source is not flushed.

## Structure
- Shared package holds:
  - the state enum (`IDLE`, `VSYNC_LOW`, `V_PRE`, `ACTIVE`, `V_POST`);
  - the line sub-phase enum (`HREF`, `HBLANK`);
  - the zero-clamp helper constants.
- One sub-module, `sensor_image_tx_line_ctrl`: the horizontal counter and `HREF`/`HBLANK` sequencing with the pixel-transfer count. It reports end-of-line to the top-level vertical FSM.

## Test plan
- **Basic frame.** Config h_active=4, h_blank=2, v_sync=1, v_pre=1, v_active=3, v_post=1; `s_valid` = 1 constantly. Expected:
  - 3 `href` pulses of exactly 4 cycles, each with `de` = 1 for all 4 cycles;
  - `vsync` low for 6 cycles;
  - `frame_done_o` pulses once per frame.
- **Source stalls.** Same config; `s_valid` low on alternate cycles. Expected: each `href` lasts 7–8 cycles with exactly 4 `de` pulses, and `line_stall_o` = 1 on each gap.
- **Zero clamps.** Config h_active=0, h_blank=0, v_active=0, v_sync=0, v_pre=0, v_post=0. Expected: 1-pixel lines, 1 line per frame, an `href` negedge every line, and no hang.
- **Mid-frame config change and disable.** Change h_active 4→8 during `ACTIVE`, and drop `enable_i` mid-frame. Expected: the current frame completes with 4-pixel lines, then the state goes to `IDLE` with outputs at 0.
- **Reset mid-line.** Assert `rst_n` = 0 during `HREF`. Expected: all outputs 0 in the same cycle; after release, `IDLE` until `enable_i` = 1.
- **Loopback.** Feed the output into the crop block with h_crop 1..3 and v_crop_size 2 of 3. Expected: 2 lines of pixels 1–2 each, matching the source sequence.
